serial_ripple_subtractor: RTL and testbench

SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

---
 rtl/serial_ripple_subtractor_pkg.sv | 18 +
 rtl/serial_ripple_subtractor_if.sv | 26 ++
 rtl/full_subtractor_bit.sv | 19 +
 rtl/serial_ripple_subtractor.sv | 88 ++++++++
 tb/tb_serial_ripple_subtractor.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/serial_ripple_subtractor_pkg.sv
// ============================================================================
// Module   : serial_ripple_subtractor_pkg
// Brief    : State encoding and default width for the serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_ripple_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] c_ST_IDLE = 2'b00;
  localparam logic [1:0] c_ST_RUN  = 2'b01;
  localparam logic [1:0] c_ST_DONE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/serial_ripple_subtractor_if.sv
// ============================================================================
// Module   : serial_ripple_subtractor_if
// Brief    : Request/result bundle between a requester and the subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_ripple_subtractor_if
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, d, bout);
  modport slave  (input start, a, b, bin, output busy, done, d, bout);
endinterface

`default_nettype wire

// File: rtl/full_subtractor_bit.sv
// ============================================================================
// Module   : full_subtractor_bit
// Brief    : One-bit combinational full subtractor cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_bit (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
// ============================================================================
// Module   : serial_ripple_subtractor
// Brief    : Bit-serial a - b - bin, one bit per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_ripple_subtractor_if.slave  bus
);
  localparam int             CW         = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  c_CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  // Minuend shifts out at bit 0 while difference bits shift in at the MSB,
  // so after WIDTH shifts this register holds the finished result.
  logic [WIDTH-1:0] r_a_res;
  logic [WIDTH-1:0] r_b;
  logic             r_brw;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_diff;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor_bit u_cell (
    .diff (w_diff),
    .bout (w_bout),
    .a    (r_a_res[0]),
    .b    (r_b[0]),
    .bin  (r_brw)
  );

  assign w_res_next = {w_diff, r_a_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_a_res <= '0;
      r_b     <= '0;
      r_brw   <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start) begin
            r_a_res <= bus.a;
            r_b     <= bus.b;
            r_brw   <= bus.bin;
            r_cnt   <= '0;
            r_state <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          r_a_res <= w_res_next;
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_brw   <= w_bout;
          r_cnt   <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) begin
            r_d     <= w_res_next;
            r_bout  <= w_bout;
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == c_ST_RUN) || (r_state == c_ST_DONE);
  assign bus.done = (r_state == c_ST_DONE);
  assign bus.d    = r_d;
  assign bus.bout = r_bout;
endmodule

`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
// ============================================================================
// Module   : tb_serial_ripple_subtractor
// Brief    : Directed self-checking bench for serial_ripple_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_ripple_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble the inputs after capture, then check latency,
  // result, single-cycle done and result hold.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] exp_d, input logic exp_bo, input string tag);
    int n;
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = ~a; bus.b = b + 4'd5; bus.bin = ~bin;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, W);
    check({tag, "_d"}, 32'(bus.d), 32'(exp_d));
    check({tag, "_bout"}, 32'(bus.bout), 32'(exp_bo));
    tick();
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, 32'(bus.d), 32'(exp_d));
  endtask

  initial begin
    int pulses;
    int last_t;
    logic [W-1:0] ed;
    logic         eb;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_d",    32'(bus.d),    32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;

    run_op(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, "d7m3");
    run_op(4'h0,    4'h1,    1'b0, 4'b1111, 1'b1, "d0m1");
    run_op(4'hF,    4'hF,    1'b1, 4'b1111, 1'b1, "dFmFb");
    run_op(4'h8,    4'h8,    1'b0, 4'h0,    1'b0, "d8m8");
    run_op(4'h3,    4'h5,    1'b1, 4'hD,    1'b1, "d3m5b");

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          ed = 4'(ia - ib - ic);
          eb = (ia < ib + ic);
          run_op(4'(ia), 4'(ib), 1'(ic), ed, eb, $sformatf("sw_%0d_%0d_%0d", ia, ib, ic));
        end

    // start during RUN must be ignored
    bus.a = 4'h9; bus.b = 4'h4; bus.bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.a = 4'h1; bus.b = 4'h2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        pulses++;
        check("ign_d", 32'(bus.d), 32'h5);
      end
      tick();
    end
    check("ign_pulses", pulses, 1);
    check("ign_hold", 32'(bus.d), 32'h5);

    // reset mid-operation aborts it
    bus.a = 4'hC; bus.b = 4'h3; bus.bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_d",    32'(bus.d),    32'd0);
    check("abort_bout", 32'(bus.bout), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("abort_nodone", pulses, 0);
    run_op(4'hC, 4'h3, 1'b0, 4'h9, 1'b0, "post_rst");

    // first start right after reset release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_op(4'h6, 4'h1, 1'b1, 4'h4, 1'b0, "rel_start");

    // held start: one result every WIDTH+2 cycles
    bus.a = 4'h5; bus.b = 4'h2; bus.bin = 1'b0; bus.start = 1'b1;
    pulses = 0;
    last_t = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.done) begin
        check("held_d", 32'(bus.d), 32'h3);
        if (last_t < 0) check("held_first", t, 5);
        else            check("held_gap", t - last_t, W + 2);
        last_t = t;
        pulses++;
      end
    end
    bus.start = 1'b0;
    check("held_pulses", pulses, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
